mem_loader: RTL

Upstream program-load stage for the 32-byte CPU RAM. It accepts a byte stream over a valid/ready handshake and writes each byte to sequential RAM addresses through the RAM's external write port (ewr/ead/edat). When the image is complete, it releases the CPU by asserting cpu_run, which drives the RAM/CPU run input; that input is low in load mode and high in run mode.

---
 rtl/mem_loader_pkg.sv | 13 +
 rtl/mem_loader_if.sv | 14 +
 rtl/mem_loader_addr_cnt.sv | 20 ++
 rtl/mem_loader.sv | 91 +++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: loader FSM state encoding and CPU RAM geometry.
package mem_loader_pkg;
  localparam int RAM_AW    = 5;
  localparam int RAM_DW    = 8;
  localparam int RAM_DEPTH = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_t;
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream handshake plus RAM external write port.
interface mem_loader_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          ewr;
  logic [AW-1:0] ead;
  logic [DW-1:0] edat;
  modport master (output in_valid, in_data, input in_ready, ewr, ead, edat);
  modport slave  (input in_valid, in_data, output in_ready, ewr, ead, edat);
endinterface

// File: rtl/mem_loader_addr_cnt.sv
// mem_loader_addr_cnt: RAM write address counter; saturates at LOAD_LEN-1 and flags it.
module mem_loader_addr_cnt #(
  parameter int AW       = 5,
  parameter int LOAD_LEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt,
  output logic          tc
);
  logic [AW-1:0] cnt_q, cnt_d;
  assign tc  = cnt_q == AW'(LOAD_LEN - 1);
  assign cnt = cnt_q;
  always_comb cnt_d = clr ? '0 : (inc & ~tc) ? cnt_q + AW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/mem_loader.sv
// mem_loader: writes LOAD_LEN stream bytes to sequential RAM addresses, then raises cpu_run.
// LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte and an ERR state on mismatch.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DW       = RAM_DW,
  parameter int AW       = RAM_AW,
  parameter int LOAD_LEN = RAM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  mem_loader_if.slave bus,
  output logic        cpu_run,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);
  state_t        state_q, state_d, fin;
  logic          in_ready_q, in_ready_d, ewr_q, ewr_d, run_q, run_d, busy_q, busy_d;
  logic [AW-1:0] ead_q, ead_d, cnt;
  logic [DW-1:0] edat_q, edat_d;
  logic          hs, wr, go, tc, last;
  assign hs = bus.in_valid & in_ready_q;
  assign go = start & (state_q inside {S_IDLE, S_RUN, S_ERR});
  mem_loader_addr_cnt #(.AW(AW), .LOAD_LEN(LOAD_LEN)) u_cnt (
    .clk, .rst, .clr(go), .inc(wr), .cnt, .tc
  );
`ifdef LOADER_CHECKSUM_EN
  logic       ck_q, ck_d, err_q, err_d;
  logic [7:0] sum_q, sum_d, sum_n;
  // ck_q marks that all data bytes are in and the next handshake is the checksum
  assign sum_n    = sum_q + 8'(bus.in_data);
  assign wr       = hs & ~ck_q;
  assign last     = hs & ck_q;
  assign fin      = (sum_n == 8'd0) ? S_FLUSH : S_ERR;
  assign ck_d     = go ? 1'b0 : ck_q | (wr & tc);
  assign sum_d    = go ? 8'd0 : hs ? sum_n : sum_q;
  assign err_d    = state_d == S_ERR;
  assign load_err = err_q;
`else
  assign wr       = hs;
  assign last     = hs & tc;
  assign fin      = S_FLUSH;
  assign load_err = 1'b0;
`endif
  always_comb begin
    state_d    = go ? S_LOAD : (state_q == S_FLUSH) ? S_RUN : last ? fin : state_q;
    in_ready_d = state_d == S_LOAD;
    busy_d     = state_d inside {S_LOAD, S_FLUSH};
    run_d      = state_d == S_RUN;
    ewr_d      = wr;
    ead_d      = wr ? cnt : ead_q;
    edat_d     = wr ? bus.in_data : edat_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      ewr_q      <= 1'b0;
      ead_q      <= '0;
      edat_q     <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      ck_q       <= 1'b0;
      sum_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      ewr_q      <= ewr_d;
      ead_q      <= ead_d;
      edat_q     <= edat_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
`ifdef LOADER_CHECKSUM_EN
      ck_q       <= ck_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  assign bus.in_ready = in_ready_q;
  assign bus.ewr      = ewr_q;
  assign bus.ead      = ead_q;
  assign bus.edat     = edat_q;
  assign cpu_run      = run_q;
  assign load_done    = run_q;
  assign busy         = busy_q;
endmodule
